// File: rtl/efpga_cfg_loader.sv
// ---------------------------------------------------------------------------
// efpga_cfg_loader
//
// Wishbone-slave configuration controller for the eFPGA fabric. Software
// writes a bitstream word by word into an internal FIFO. After START, the
// words are streamed to the fabric configuration port with a valid/ready
// handshake until LEN words have been sent.
//
// Register map (byte offsets from BASE_ADDR):
//   0x00 CTRL   WO  bit0 START, bit1 ABORT (self-clearing pulses)
//   0x04 LEN    RW  LEN_W-bit word count
//   0x08 STATUS RO  bit0 busy, bit1 done, bit2 error, bit3 timeout,
//                   [15:8] FIFO level, [31:16] sent count
//   0x0C DATA   WO  push one word into the FIFO
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   wbs_*                     Wishbone slave (registered one-cycle ack)
//   cfg_data/cfg_valid        configuration word and its valid to the fabric
//   cfg_ready                 fabric accepts the current word
//   cfg_active                fabric is held in configuration mode
//   cfg_done                  configuration completed
//
// Optional feature: define EFPGA_CFG_TIMEOUT_EN to add a stall watchdog that
// moves LOAD to ERROR after TIMEOUT consecutive stalled cycles.
// ---------------------------------------------------------------------------
module efpga_cfg_loader #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LEN_W      = 16,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [31:0] cfg_data,
    output logic        cfg_valid,
    input  logic        cfg_ready,
    output logic        cfg_active,
    output logic        cfg_done
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDone,
        StError
    } state_e;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   sent_q, sent_d;
    logic               error_q, error_d;
    logic               ack_q, ack_d;
    logic [31:0]        dat_q, dat_d;

    logic [31:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // -----------------------------------------------------------------------
    // Bus decode
    // -----------------------------------------------------------------------
    logic        blk_hit;
    logic [5:0]  reg_idx;
    logic        req;
    logic        data_wr_req;
    logic        push_wait;
    logic        acc;
    logic        wr_ctrl;
    logic        wr_len;
    logic        start_req;
    logic        abort_req;
    logic        push;
    logic        pop;
    logic        flush;
    logic        full;
    logic        timeout_hit;
    logic        tmo_flag;

    logic        unused_bits;
    assign unused_bits = ^{wbs_sel_i, wbs_adr_i[1:0]};

    assign blk_hit = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign reg_idx = wbs_adr_i[7:2];

    // Blocking on ack_q keeps the ack a single-cycle pulse even if the master
    // holds stb across the acknowledge.
    assign req         = wbs_stb_i && wbs_cyc_i && blk_hit && !ack_q;
    assign full        = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop         = cfg_valid && cfg_ready;
    assign data_wr_req = req && wbs_we_i && (reg_idx == 6'd3);

    // A pop in the same cycle frees a slot, so the push can complete now.
    assign push_wait = data_wr_req && (state_q != StError) && full && !pop;
    assign ack_d     = req && !push_wait;
    assign acc       = ack_d;

    assign wr_ctrl   = acc && wbs_we_i && (reg_idx == 6'd0);
    assign wr_len    = acc && wbs_we_i && (reg_idx == 6'd1);
    assign abort_req = wr_ctrl && wbs_dat_i[1];
    assign start_req = wr_ctrl && wbs_dat_i[0] && !wbs_dat_i[1];

    assign flush = abort_req || timeout_hit;
    assign push  = data_wr_req && acc && (state_q != StError) && !flush;

    // -----------------------------------------------------------------------
    // Fabric side
    // -----------------------------------------------------------------------
    assign cfg_data   = mem_q[rd_ptr_q];
    assign cfg_valid  = (state_q == StLoad) && (count_q != '0);
    assign cfg_active = (state_q == StLoad);
    assign cfg_done   = (state_q == StDone);

    // -----------------------------------------------------------------------
    // Optional stall watchdog
    // -----------------------------------------------------------------------
`ifdef EFPGA_CFG_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT + 1);

    logic [STALL_W-1:0] stall_q, stall_d;
    logic               tmo_q, tmo_d;

    always_comb begin
        stall_d     = '0;
        timeout_hit = 1'b0;
        tmo_d       = tmo_q;
        if (cfg_valid && !cfg_ready) begin
            if (stall_q == STALL_W'(TIMEOUT - 1)) begin
                timeout_hit = 1'b1;
                tmo_d       = 1'b1;
            end else begin
                stall_d = stall_q + STALL_W'(1);
            end
        end
        if (abort_req) begin
            tmo_d = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            stall_q <= '0;
            tmo_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            tmo_q   <= tmo_d;
        end
    end

    assign tmo_flag = tmo_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT == 0);
    assign timeout_hit    = 1'b0;
    assign tmo_flag       = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // FIFO pointers and level
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    logic [LEN_W-1:0] sent_inc;
    assign sent_inc = sent_q + LEN_W'(1);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        sent_d  = sent_q;
        error_d = error_q;

        if (pop) begin
            sent_d = sent_inc;
        end

        if (wr_len && (state_q != StLoad)) begin
            len_d = wbs_dat_i[LEN_W-1:0];
        end

        case (state_q)
            StIdle, StDone: begin
                if (start_req) begin
                    sent_d = '0;
                    if (len_q != '0) begin
                        state_d = StLoad;
                    end else begin
                        state_d = StError;
                        error_d = 1'b1;
                    end
                end
            end
            StLoad: begin
                if (timeout_hit) begin
                    state_d = StError;
                    error_d = 1'b1;
                end else if (pop && (sent_inc == len_q)) begin
                    state_d = StDone;
                end
            end
            StError: begin
                error_d = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // ABORT overrides everything else, including a concurrent START.
        if (abort_req) begin
            state_d = StIdle;
            sent_d  = '0;
            if (state_q == StLoad) begin
                error_d = 1'b1;
            end else if (state_q == StError) begin
                error_d = 1'b0;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read data
    // -----------------------------------------------------------------------
    logic [31:0] level_ext;
    logic [7:0]  level8;
    logic [31:0] status;
    logic [31:0] rdata;

    assign level_ext = 32'(count_q);
    assign level8    = (level_ext > 32'd255) ? 8'hFF : level_ext[7:0];
    assign status    = {16'(sent_q), level8, 4'b0000, tmo_flag, error_q, cfg_done, cfg_active};

    always_comb begin
        rdata = '0;
        case (reg_idx)
            6'd1:    rdata = 32'(len_q);
            6'd2:    rdata = status;
            default: rdata = '0;
        endcase
    end

    assign dat_d = (acc && !wbs_we_i) ? rdata : 32'h0;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= StIdle;
            len_q    <= '0;
            sent_q   <= '0;
            error_q  <= 1'b0;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            sent_q   <= sent_d;
            error_q  <= error_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= wbs_dat_i;
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

endmodule
